// File: rtl/yc_pkg.sv
// Shared definitions for the Y/C separator.
//   sample_t      default-width signed composite sample
//   LOG2_WIN      shift that turns the window sum into the window mean
//   sat_sample()  clamps a wide signed value into a signed w-bit range
package yc_pkg;

  localparam int YC_DATA_WIDTH  = 12;
  localparam int YC_WINDOW_SIZE = 32;
  localparam int LOG2_WIN       = $clog2(YC_WINDOW_SIZE);

  typedef logic signed [YC_DATA_WIDTH-1:0] sample_t;

  // Clamp x into [-2^(w-1), 2^(w-1)-1]. The result is still 32 bits wide;
  // the caller keeps the low w bits.
  function automatic logic signed [31:0] sat_sample(input logic signed [31:0] x,
                                                    input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/yc_boxcar_avg.sv
// Moving-average (boxcar) low-pass over the last WINDOW_SIZE samples.
//   clk, rst  pixel clock, asynchronous active-high reset
//   data_in   signed sample, one per clock
//   centre    shift_reg[WINDOW_SIZE/2], the window-centre sample (combinational)
//   mean      acc >>> log2(WINDOW_SIZE), mean of the current window (combinational)
//   luma      mean registered on each edge
module yc_boxcar_avg
  import yc_pkg::*;
#(
  parameter int DATA_WIDTH  = YC_DATA_WIDTH,
  parameter int WINDOW_SIZE = YC_WINDOW_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] centre,
  output logic signed [DATA_WIDTH-1:0] mean,
  output logic signed [DATA_WIDTH-1:0] luma
);

  localparam int LOG2 = $clog2(WINDOW_SIZE);
  // Sum of WINDOW_SIZE samples needs log2(WINDOW_SIZE) extra bits; no overflow.
  localparam int AW   = DATA_WIDTH + LOG2;

  if (WINDOW_SIZE < 2 || (WINDOW_SIZE & (WINDOW_SIZE - 1)) != 0) begin : g_bad_window
    $error("yc_boxcar_avg: WINDOW_SIZE must be a power of two >= 2");
  end

  logic signed [DATA_WIDTH-1:0] shift_reg [0:WINDOW_SIZE-1];
  logic signed [AW-1:0]         acc;

  // acc tracks the sum of shift_reg: add the incoming sample, drop the one
  // falling off the end of the delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WINDOW_SIZE; i++) shift_reg[i] <= '0;
      acc  <= '0;
      luma <= '0;
    end else begin
      shift_reg[0] <= data_in;
      for (int i = 1; i < WINDOW_SIZE; i++) shift_reg[i] <= shift_reg[i-1];
      acc  <= acc + AW'(data_in) - AW'(shift_reg[WINDOW_SIZE-1]);
      luma <= mean;
    end
  end

  // Arithmetic shift floors toward minus infinity; the mean of in-range
  // samples always fits back into DATA_WIDTH bits.
  assign mean   = DATA_WIDTH'(acc >>> LOG2);
  assign centre = shift_reg[WINDOW_SIZE/2];

endmodule

// File: rtl/yc_separator.sv
// Composite-video Y/C separator: luma is the boxcar mean of the window,
// chroma is the window-centre sample minus that mean (saturated).
//   clk         pixel clock
//   rst         asynchronous active-high reset
//   data_in     signed composite sample, one per clock
//   luma_out    signed Y estimate (registered)
//   chroma_out  signed C estimate (registered)
module yc_separator
  import yc_pkg::*;
#(
  parameter int DATA_WIDTH  = YC_DATA_WIDTH,
  parameter int WINDOW_SIZE = YC_WINDOW_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] luma_out,
  output logic signed [DATA_WIDTH-1:0] chroma_out
);

  if (DATA_WIDTH < 2 || DATA_WIDTH > 31) begin : g_bad_width
    $error("yc_separator: DATA_WIDTH must be in 2..31");
  end

  logic signed [DATA_WIDTH-1:0] centre;
  logic signed [DATA_WIDTH-1:0] mean;
  logic signed [DATA_WIDTH:0]   diff;
  logic signed [31:0]           diff_sat;

  yc_boxcar_avg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WINDOW_SIZE (WINDOW_SIZE)
  ) u_avg (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .centre  (centre),
    .mean    (mean),
    .luma    (luma_out)
  );

  // One extra bit holds any difference of two in-range samples exactly;
  // the clamp then keeps large high-frequency steps from wrapping sign.
  assign diff     = (DATA_WIDTH+1)'(centre) - (DATA_WIDTH+1)'(mean);
  assign diff_sat = sat_sample(32'(diff), DATA_WIDTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chroma_out <= '0;
    else     chroma_out <= DATA_WIDTH'(diff_sat);
  end

endmodule

// File: tb/tb_yc_separator.sv
module tb_yc_separator;

  localparam int DW = 12;
  localparam int W  = 32;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));

  logic                 clk;
  logic                 rst;
  logic signed [DW-1:0] data_in;
  logic signed [DW-1:0] luma_out;
  logic signed [DW-1:0] chroma_out;

  int vectors = 0;
  int miscompares = 0;

  // Reference window: win[0] is the newest sample, win[W-1] the oldest.
  int win[$];

  yc_separator #(.DATA_WIDTH(DW), .WINDOW_SIZE(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .luma_out   (luma_out),
    .chroma_out (chroma_out)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int clamp(input int x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  task automatic model_reset();
    win.delete();
    for (int i = 0; i < W; i++) win.push_back(0);
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1: drive a sample, advance the model, check after the edge.
  task automatic step(input int d, input string tag);
    int s;
    int m;
    int exp_y;
    int exp_c;
    logic [31:0] dv;
    s = 0;
    foreach (win[i]) s += win[i];
    m = floor_div(s, W);
    exp_y = m;
    exp_c = clamp(win[W/2] - m);
    win.push_front(d);
    void'(win.pop_back());
    dv = d;
    data_in = dv[DW-1:0];
    @(posedge clk);
    #1;
    check({tag, " luma"}, luma_out, exp_y);
    check({tag, " chroma"}, chroma_out, exp_c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic signed [31:0] c_prev;
    rst = 1'b1;
    data_in = '0;
    model_reset();

    // 1. Flush under reset
    repeat (W + 5) @(posedge clk);
    #1;
    check("flush luma", luma_out, 0);
    check("flush chroma", chroma_out, 0);
    rst = 1'b0;
    step(0, "post_reset");

    // 2. DC
    for (int i = 0; i < 2 * W; i++) step(2000, "dc");
    check("dc final luma", luma_out, 2000);
    check("dc final chroma", chroma_out, 0);

    // 3. Carrier
    for (int i = 0; i < 2 * W; i++) step((i % 2 == 0) ? 1100 : 1000, "carrier");
    check("carrier luma", luma_out, 1050);
    c_prev = chroma_out;
    check("carrier chroma mag", 32'((c_prev == 50) || (c_prev == -50)), 1);
    step(1100, "carrier");
    check("carrier alternates", chroma_out, -c_prev);

    // 4. Drop
    for (int i = 0; i < W + 1; i++) step(0, "drop");
    check("drop luma", luma_out, 0);
    check("drop chroma", chroma_out, 0);

    // 5. Saturation: a lone 2047 in a window of -2048 reaches the centre tap
    for (int i = 0; i < W + 1; i++) step(MINV, "sat_fill");
    step(MAXV, "sat_step");
    for (int i = 0; i < 20; i++) begin
      step(MINV, "sat_tail");
      if (i == 16) check("sat clamp", chroma_out, MAXV);
    end
    // Rising step the other way drives chroma negative
    for (int i = 0; i < W + 1; i++) step(MAXV, "sat_hi");
    for (int i = 0; i < 20; i++) step(MINV, "sat_neg");
    for (int i = 0; i < W + 1; i++) step(-1000, "neg_dc");
    check("neg dc luma", luma_out, -1000);
    check("neg dc chroma", chroma_out, 0);

    // 6. Async reset mid-carrier, between edges
    for (int i = 0; i < W + 4; i++) step((i % 2 == 0) ? 1100 : 1000, "carrier2");
    #2;
    rst = 1'b1;
    #1;
    check("async rst luma", luma_out, 0);
    check("async rst chroma", chroma_out, 0);
    model_reset();
    data_in = 12'sd1234;
    repeat (2) @(posedge clk);
    #1;
    check("rst held luma", luma_out, 0);
    check("rst held chroma", chroma_out, 0);
    rst = 1'b0;
    for (int i = 0; i < W + 1; i++) step(500, "dc500");
    check("dc500 luma", luma_out, 500);
    check("dc500 chroma", chroma_out, 0);

    // Random full-range and small-range stimulus against the model
    for (int i = 0; i < 300; i++) step(int'($urandom_range(0, 4095)) - 2048, "rand_full");
    for (int i = 0; i < 200; i++) step(int'($urandom_range(0, 400)) - 200, "rand_small");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
